// File: rtl/fetch_ctrl.sv
// fetch_ctrl: multi-cycle instruction fetch and PC-update controller for the word-addressed MIPS core.
// Define FETCH_TIMEOUT_EN to add a fetch watchdog that halts with a sticky fetch_err.
module fetch_ctrl #(
    parameter int EXEC_CYCLES = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        stall,
    output logic [31:0] ir,
    output logic        pc_update,
    output logic        pcsel,
    output logic        jump,
    output logic        isJR,
    output logic        link_we,
    output logic        halted,
    output logic        fetch_err
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, COMMIT, HALT} state_t;
    typedef enum logic [2:0] {C_SEQ, C_J, C_JAL, C_BEQ, C_BNE, C_JR, C_HLT} cls_t;
    state_t     state, nxt;
    cls_t       cls, dec;
    logic [3:0] cnt;
    logic       tmo;
    always_comb begin
        dec = ir[31:26] == 6'h02 ? C_J :
              ir[31:26] == 6'h03 ? C_JAL :
              ir[31:26] == 6'h04 ? C_BEQ :
              ir[31:26] == 6'h05 ? C_BNE :
              ir[31:26] == 6'h3F ? C_HLT :
              (ir[31:26] == 6'h00 && ir[5:0] == 6'h08) ? C_JR : C_SEQ;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = FETCH;
            FETCH:   nxt = imem_ack ? DECODE : tmo ? HALT : FETCH;
            DECODE:  nxt = EXEC;
            EXEC:    nxt = (cnt == 4'd0 && !stall) ? COMMIT : EXEC;
            COMMIT:  nxt = cls == C_HLT ? HALT : FETCH;
            HALT:    nxt = HALT;
            default: nxt = IDLE;
        endcase
    end
`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    assign tmo = tcnt == TW'(TIMEOUT - 1);
    // Counter is zero whenever outside FETCH, so every FETCH entry starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt      <= '0;
            fetch_err <= 1'b0;
        end else begin
            tcnt <= state == FETCH ? tcnt + 1'b1 : '0;
            if (state == FETCH && !imem_ack && tmo) fetch_err <= 1'b1;
        end
    end
`else
    assign tmo       = 1'b0;
    assign fetch_err = 1'b0;
`endif
    // Outputs are registered from the next state so they line up with the state they decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cls       <= C_SEQ;
            cnt       <= 4'd0;
            ir        <= 32'd0;
            imem_req  <= 1'b0;
            pc_update <= 1'b0;
            pcsel     <= 1'b0;
            jump      <= 1'b0;
            isJR      <= 1'b0;
            link_we   <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state <= nxt;
            if (state == FETCH && imem_ack) ir <= instr;
            if (state == DECODE) begin
                cls <= dec;
                cnt <= 4'(EXEC_CYCLES - 1);
            end
            if (state == EXEC && cnt != 4'd0) cnt <= cnt - 1'b1;
            imem_req  <= nxt == FETCH;
            halted    <= nxt == HALT;
            pc_update <= nxt == COMMIT && cls != C_HLT;
            pcsel     <= nxt == COMMIT && ((cls == C_BEQ && zero) || (cls == C_BNE && !zero));
            jump      <= nxt == COMMIT && (cls == C_J || cls == C_JAL);
            link_we   <= nxt == COMMIT && cls == C_JAL;
            isJR      <= nxt == COMMIT && cls == C_JR;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        zero = 1'b0, stall = 1'b0;
    logic [31:0] ir;
    logic        pc_update, pcsel, jump, isJR, link_we, halted, fetch_err;
    int          checks = 0, errors = 0;
    int          hits;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ack(imem_ack),
        .instr(instr), .zero(zero), .stall(stall), .ir(ir), .pc_update(pc_update),
        .pcsel(pcsel), .jump(jump), .isJR(isJR), .link_we(link_we),
        .halted(halted), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // outputs packed as {imem_req,pc_update,pcsel,jump,isJR,link_we,halted,fetch_err}
    function automatic logic [7:0] outs();
        return {imem_req, pc_update, pcsel, jump, isJR, link_we, halted, fetch_err};
    endfunction

    // Entered with the DUT just in FETCH; returns with it back in FETCH.
    task automatic run_instr(input string tag, input logic [31:0] w, input logic z,
                             input logic [3:0] sel);
        instr = w; zero = z; imem_ack = 1'b1;
        step(1);
        imem_ack = 1'b0;
        check({tag, "_ir"}, ir, w);
        check({tag, "_req_drop"}, {31'd0, imem_req}, 32'd0);
        step(2);
        check({tag, "_exec"}, {24'd0, outs()}, 32'd0);
        step(1);
        check({tag, "_commit"}, {24'd0, outs()}, {24'd0, 2'b01, sel, 2'b00});
        step(1);
        check({tag, "_refetch"}, {24'd0, outs()}, 32'h80);
    endtask

    initial begin
        step(2);
        check("reset_outs", {24'd0, outs()}, 32'd0);
        check("reset_ir", ir, 32'd0);
        reset = 1'b0;
        instr = 32'h0000_0020; imem_ack = 1'b1;
        step(1);
        check("c1_fetch", {24'd0, outs()}, 32'h80);
        step(1);
        imem_ack = 1'b0;
        check("c2_decode", {24'd0, outs()}, 32'd0);
        step(2);
        check("c4_no_pc", {31'd0, pc_update}, 32'd0);
        step(1);
        check("c5_seq_commit", {24'd0, outs()}, 32'h40);
        step(1);
        check("c6_refetch", {24'd0, outs()}, 32'h80);
        // sel = {pcsel, jump, isJR, link_we}
        run_instr("beq_t",  32'h1000_0003, 1'b1, 4'b1000);
        run_instr("beq_nt", 32'h1000_0003, 1'b0, 4'b0000);
        run_instr("bne_z",  32'h1400_0003, 1'b1, 4'b0000);
        run_instr("bne_nz", 32'h1400_0003, 1'b0, 4'b1000);
        run_instr("j",      32'h0800_0010, 1'b0, 4'b0100);
        run_instr("jal",    32'h0C00_0010, 1'b1, 4'b0101);
        run_instr("jr",     32'h03E0_0008, 1'b1, 4'b0010);
        run_instr("sll",    32'h0000_0000, 1'b1, 4'b0000);

        // stall applied once the exec counter has reached zero
        instr = 32'h0000_0020; imem_ack = 1'b1;
        step(1);
        imem_ack = 1'b0;
        step(2);
        stall = 1'b1;
        hits = 0;
        repeat (4) begin
            step(1);
            if (pc_update) hits++;
        end
        check("stall_no_pc", hits, 0);
        stall = 1'b0;
        step(1);
        check("stall_commit", {24'd0, outs()}, 32'h40);
        step(1);

        // halt instruction
        instr = 32'hFC00_0000; imem_ack = 1'b1;
        step(1);
        imem_ack = 1'b0;
        step(3);
        check("halt_commit", {24'd0, outs()}, 32'd0);
        step(1);
        check("halt_state", {24'd0, outs()}, 32'h02);
        hits = 0;
        imem_ack = 1'b1;
        repeat (20) begin
            step(1);
            if (pc_update || imem_req || !halted) hits++;
        end
        imem_ack = 1'b0;
        check("halt_hold", hits, 0);
        reset = 1'b1;
        #1;
        check("halt_reset", {24'd0, outs()}, 32'd0);
        step(1);
        reset = 1'b0;
        step(1);
        check("halt_recover", {24'd0, outs()}, 32'h80);

        // reset in the middle of EXEC
        instr = 32'h0C00_0010; imem_ack = 1'b1;
        step(1);
        imem_ack = 1'b0;
        step(1);
        reset = 1'b1;
        #1;
        check("midexec_outs", {24'd0, outs()}, 32'd0);
        check("midexec_ir", ir, 32'd0);
        step(1);
        reset = 1'b0;
        step(1);
        check("midexec_recover", {24'd0, outs()}, 32'h80);
`ifdef FETCH_TIMEOUT_EN
        // ack withheld: FETCH cycles 1..16 elapse, HALT on the 16th edge
        step(15);
        check("tmo_wait", {24'd0, outs()}, 32'h80);
        step(1);
        check("tmo_fire", {24'd0, outs()}, 32'h03);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        check("tmo_cleared", {24'd0, outs()}, 32'h80);
        step(15);
        instr = 32'h0000_0020; imem_ack = 1'b1;
        step(1);
        imem_ack = 1'b0;
        check("tmo_ack_wins", {24'd0, outs()}, 32'd0);
        check("tmo_ack_ir", ir, 32'h0000_0020);
        step(3);
        check("tmo_ack_commit", {24'd0, outs()}, 32'h40);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Multi-cycle instruction-fetch and PC-update controller for the word-addressed MIPS core. It requests instructions from instruction memory over a req/ack handshake and latches them into the instruction register. It classifies each instruction as sequential, branch, jump or jump-register, then issues a single-cycle PC-update strobe with the matching PC-select controls. It sits between instruction memory, the ALU zero flag, the hazard unit and the PC register.

## Interface
- EXEC_CYCLES, 2: cycles spent in EXEC for ALU/register settle; legal range 1–15.
- TIMEOUT, 16: fetch watchdog limit in cycles; used only with FETCH_TIMEOUT_EN.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- imem_req  out  1  fetch request, high throughout FETCH.
- imem_ack  in  1  instruction valid on instr this cycle.
- instr  in  32  instruction word from memory.
- zero  in  1  ALU zero flag.
- stall  in  1  hazard hold; blocks EXEC exit.
- ir  out  32  latched instruction register.
- pc_update  out  1  PC register advances this cycle only.
- pcsel  out  1  taken branch (PC+1+offset).
- jump  out  1  J/JAL target select.
- isJR  out  1  JR register-target select.
- link_we  out  1  JAL link write (PC+1 into $31).
- halted  out  1  core halted.
- fetch_err  out  1  sticky watchdog error (0 without macro).

## Operation
- States: IDLE, FETCH, DECODE, EXEC, COMMIT, HALT. Moore outputs decoded from state and registered class bits.
- IDLE: reset state. Goes to FETCH on the next clock.
- FETCH: imem_req=1. On a clock edge with imem_ack=1: ir<=instr, go to DECODE. Otherwise stay.
- DECODE (1 cycle), class from ir[31:26] (registered):
  - 6'h02 J.
  - 6'h03 JAL.
  - 6'h04 BEQ.
  - 6'h05 BNE.
  - 6'h00 with ir[5:0]=6'h08 JR.
  - 6'h3F HALT.
  - anything else: SEQ.
  - Load exec counter with EXEC_CYCLES-1. Go to EXEC.
- EXEC: counter decrements each cycle. Exits to COMMIT when the counter is 0 and stall=0; stall=1 holds EXEC indefinitely. zero is registered on the exit edge (taken_q).
- COMMIT (1 cycle), exactly one of these target selects, all others 0:
  - SEQ: pc_update=1 only.
  - BEQ/BNE: pc_update=1; pcsel = taken_q for BEQ, ~taken_q for BNE.
  - J: pc_update=1, jump=1.
  - JAL: pc_update=1, jump=1, link_we=1.
  - JR: pc_update=1, isJR=1.
  - HALT: pc_update=0; go to HALT.
  - All other classes return to FETCH.
- HALT: halted=1, imem_req=0, all strobes 0. Left only by reset.
- Outside COMMIT: pc_update, pcsel, jump, isJR, link_we are all 0.

## Timing
- Reset values: state=IDLE; ir=0; imem_req, pc_update, pcsel, jump, isJR, link_we, halted, fetch_err all 0.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. Any in-flight ack is ignored.
- Instruction period: 1 (IDLE→FETCH, first only) + fetch wait W (W≥1, W=1 when ack is present in the first FETCH cycle) + 1 DECODE + EXEC_CYCLES + stall cycles + 1 COMMIT. Defaults with no wait or stall: 5 cycles per instruction.
- imem_req drops the cycle after ack is accepted. ack outside FETCH is ignored.
- Exactly one pc_update pulse per non-HALT instruction. Never two pulses in consecutive cycles.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter runs while in FETCH and clears on entry to FETCH.
  - If TIMEOUT cycles elapse without ack: fetch_err<=1 (sticky until reset), state→HALT, halted=1.
  - An ack arriving on the TIMEOUT-th cycle is accepted (ack wins).
- FETCH_TIMEOUT_EN undefined: FETCH waits forever; fetch_err is constant 0; no counter logic.

## Test plan
- Reset, then ack in the first FETCH cycle with instr=32'h00000020 (SEQ) → pc_update high exactly at cycle 5 after reset release; all selects 0.
- instr=32'h1000_0003 (BEQ) with zero=1 → COMMIT pcsel=1. Repeat with zero=0 → pcsel=0, pc_update=1. BNE (32'h1400_0003) gives the inverse.
- instr=32'h0C00_0010 (JAL) → COMMIT jump=1, link_we=1. instr=32'h03E0_0008 (JR $31) → isJR=1, jump=0.
- stall held high for 4 cycles during EXEC → COMMIT delayed by exactly 4 cycles; no pc_update while stalled.
- instr=32'hFC00_0000 → halted=1, imem_req stays 0, no pc_update for 20 cycles. Reset recovers to IDLE.
- With FETCH_TIMEOUT_EN, withhold ack for 16 cycles → fetch_err=1, halted=1. Repeat with ack on cycle 16 → accepted, fetch_err=0. Assert reset mid-EXEC → all outputs 0 immediately.
